// File: rtl/encoder_scheduler.sv
// Walks the input buffer through the vocabulary matcher and emits one token per match.
// Optional match watchdog is enabled with `define ENCODER_SCHED_TIMEOUT_EN.
module encoder_scheduler #(
  parameter int ADDR_WIDTH  = 4,
  parameter int TOKEN_WIDTH = 8,
  parameter int LEN_WIDTH   = 4,
  parameter int UNK_ID      = 0
`ifdef ENCODER_SCHED_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   m_start,
  output logic [ADDR_WIDTH-1:0]  m_base,
  input  logic                   m_done,
  input  logic                   m_found,
  input  logic [LEN_WIDTH-1:0]   m_len,
  input  logic [TOKEN_WIDTH-1:0] m_token,
  input  logic                   m_end,
  output logic                   tok_valid,
  input  logic                   tok_ready,
  output logic [TOKEN_WIDTH-1:0] tok_id,
  output logic                   tok_unk,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_WIDTH:0]    tok_count,
  output logic                   error
);

  // Wide enough that ptr + step can never wrap before the exhaustion test.
  localparam int SUM_W = ((ADDR_WIDTH > LEN_WIDTH) ? ADDR_WIDTH : LEN_WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    EMIT   = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t                 state_r, state_next_s;
  logic [ADDR_WIDTH-1:0]  ptr_r, ptr_next_s;
  logic [LEN_WIDTH-1:0]   step_r, step_next_s;
  logic [TOKEN_WIDTH-1:0] tok_id_r, tok_id_next_s;
  logic                   tok_unk_r, tok_unk_next_s;
  logic [ADDR_WIDTH:0]    tok_count_r, tok_count_next_s;
  logic                   error_r, error_next_s;
  logic                   m_start_r, tok_valid_r, busy_r, done_r;
  logic [SUM_W-1:0]       next_addr_s;
  logic                   exhausted_s;
  logic                   timeout_s;

  assign next_addr_s = SUM_W'(ptr_r) + SUM_W'(step_r);
  assign exhausted_s = |next_addr_s[SUM_W-1:ADDR_WIDTH];

`ifdef ENCODER_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_r;

  // Watchdog: counts cycles spent in WAIT, restarts whenever WAIT is left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r != WAIT) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end
  end

  assign timeout_s = (state_r == WAIT) && !m_done &&
                     (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state and datapath update.
  always_comb begin
    state_next_s     = state_r;
    ptr_next_s       = ptr_r;
    step_next_s      = step_r;
    tok_id_next_s    = tok_id_r;
    tok_unk_next_s   = tok_unk_r;
    tok_count_next_s = tok_count_r;
    error_next_s     = error_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s     = LAUNCH;
          ptr_next_s       = {ADDR_WIDTH{1'b0}};
          tok_count_next_s = {(ADDR_WIDTH+1){1'b0}};
          error_next_s     = 1'b0;
        end else begin
          state_next_s = IDLE;
        end
      end
      LAUNCH: begin
        state_next_s = WAIT;
      end
      WAIT: begin
        if (m_done) begin
          if (m_end) begin
            state_next_s = FINISH;
          end else if (m_found && (m_len != {LEN_WIDTH{1'b0}})) begin
            tok_id_next_s  = m_token;
            tok_unk_next_s = 1'b0;
            step_next_s    = m_len;
            state_next_s   = EMIT;
          end else begin
            // A zero-length hit is reported as an error but still advances like UNK.
            tok_id_next_s  = TOKEN_WIDTH'(UNK_ID);
            tok_unk_next_s = 1'b1;
            step_next_s    = LEN_WIDTH'(1);
            error_next_s   = error_r | m_found;
            state_next_s   = EMIT;
          end
        end else if (timeout_s) begin
          error_next_s = 1'b1;
          state_next_s = FINISH;
        end else begin
          state_next_s = WAIT;
        end
      end
      EMIT: begin
        if (tok_ready) begin
          tok_count_next_s = tok_count_r + (ADDR_WIDTH+1)'(1);
          if (exhausted_s) begin
            state_next_s = FINISH;
          end else begin
            ptr_next_s   = next_addr_s[ADDR_WIDTH-1:0];
            state_next_s = LAUNCH;
          end
        end else begin
          state_next_s = EMIT;
        end
      end
      FINISH: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath registers and registered outputs decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r       <= {ADDR_WIDTH{1'b0}};
      step_r      <= {LEN_WIDTH{1'b0}};
      tok_id_r    <= {TOKEN_WIDTH{1'b0}};
      tok_unk_r   <= 1'b0;
      tok_count_r <= {(ADDR_WIDTH+1){1'b0}};
      error_r     <= 1'b0;
      m_start_r   <= 1'b0;
      tok_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      ptr_r       <= ptr_next_s;
      step_r      <= step_next_s;
      tok_id_r    <= tok_id_next_s;
      tok_unk_r   <= tok_unk_next_s;
      tok_count_r <= tok_count_next_s;
      error_r     <= error_next_s;
      m_start_r   <= (state_next_s == LAUNCH);
      tok_valid_r <= (state_next_s == EMIT);
      busy_r      <= (state_next_s != IDLE);
      done_r      <= (state_next_s == FINISH);
    end
  end

  assign m_start   = m_start_r;
  assign m_base    = ptr_r;
  assign tok_valid = tok_valid_r;
  assign tok_id    = tok_id_r;
  assign tok_unk   = tok_unk_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign tok_count = tok_count_r;
  assign error     = error_r;

endmodule

// File: tb/tb_encoder_scheduler.sv
// Self-checking bench for encoder_scheduler: acts as the matcher and downstream sink,
// and predicts each pass from a list of matcher responses.
module tb_encoder_scheduler;
  localparam int AW  = 4;
  localparam int TW  = 8;
  localparam int LW  = 4;
  localparam int UNK = 0;

  logic clk = 1'b0;
  logic rst, start, m_done, m_found, m_end, tok_ready;
  logic [LW-1:0] m_len;
  logic [TW-1:0] m_token;
  logic m_start, tok_valid, tok_unk, busy, done, error;
  logic [AW-1:0] m_base;
  logic [TW-1:0] tok_id;
  logic [AW:0]   tok_count;

  int tests = 0;
  int fails = 0;

  typedef struct { bit e; bit f; int len; int tok; } resp_t;
  resp_t resp_q[$];
  int exp_base_q[$];
  int exp_tok_q[$];
  int exp_unk_q[$];
  int exp_count;
  bit exp_err;

  always #5 clk = ~clk;

  encoder_scheduler #(
    .ADDR_WIDTH(AW), .TOKEN_WIDTH(TW), .LEN_WIDTH(LW), .UNK_ID(UNK)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .m_start(m_start), .m_base(m_base), .m_done(m_done), .m_found(m_found),
    .m_len(m_len), .m_token(m_token), .m_end(m_end),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_id(tok_id), .tok_unk(tok_unk),
    .busy(busy), .done(done), .tok_count(tok_count), .error(error)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit e, input bit f, input int len, input int tok);
    resp_t r;
    r.e = e; r.f = f; r.len = len; r.tok = tok;
    resp_q.push_back(r);
  endtask

  // Reference: walk the buffer address by address using the matcher responses in order.
  task automatic build_model;
    int ptr, step;
    exp_base_q.delete(); exp_tok_q.delete(); exp_unk_q.delete();
    exp_count = 0; exp_err = 1'b0; ptr = 0;
    for (int i = 0; i < resp_q.size(); i++) begin
      exp_base_q.push_back(ptr);
      if (resp_q[i].e) break;
      if (resp_q[i].f && resp_q[i].len != 0) begin
        exp_tok_q.push_back(resp_q[i].tok);
        exp_unk_q.push_back(0);
        step = resp_q[i].len;
      end else begin
        exp_tok_q.push_back(UNK);
        exp_unk_q.push_back(1);
        step = 1;
        if (resp_q[i].f) exp_err = 1'b1;
      end
      exp_count++;
      ptr = ptr + step;
      if (ptr >= (1 << AW)) break;
    end
  endtask

  task automatic finish_check;
    check("done_pulse", done, 1);
    check("tok_count", tok_count, exp_count);
    check("error_final", error, exp_err);
    check("no_mstart_at_finish", m_start, 0);
    check("no_valid_at_finish", tok_valid, 0);
    tick;
    check("done_one_cycle", done, 0);
    check("idle_not_busy", busy, 0);
    check("count_holds", tok_count, exp_count);
    tick;
    check("no_mstart_after_pass", m_start, 0);
  endtask

  task automatic run_pass(input bit poke);
    bit ok;
    int d, bp;
    logic [TW-1:0] held;
    build_model();
    start = 1'b1; tick; start = 1'b0;
    check("start_to_mstart", m_start, 1);
    check("error_cleared", error, 0);
    check("count_cleared", tok_count, 0);
    check("busy_on_start", busy, 1);
    for (int i = 0; i < exp_base_q.size(); i++) begin
      ok = 1'b0;
      for (int c = 0; c < 50; c++) begin
        if (m_start) begin ok = 1'b1; break; end
        tick;
      end
      if (!ok) begin
        check("mstart_timeout", m_start, 1);
        rst = 1'b1; tick; rst = 1'b0;
        return;
      end
      check("m_base", m_base, exp_base_q[i]);
      tick;
      check("mstart_single_pulse", m_start, 0);
      d = $urandom_range(0, 3);
      repeat (d) begin
        if (poke) start = 1'b1;
        tick;
        start = 1'b0;
        check("wait_holds", tok_valid, 0);
      end
      m_done = 1'b1; m_found = resp_q[i].f; m_end = resp_q[i].e;
      m_len = resp_q[i].len[LW-1:0]; m_token = resp_q[i].tok[TW-1:0];
      tick;
      m_done = 1'b0; m_found = 1'b0; m_end = 1'b0; m_len = '0; m_token = '0;
      if (resp_q[i].e) begin
        finish_check();
        return;
      end
      check("tok_valid", tok_valid, 1);
      check("tok_id", tok_id, exp_tok_q[i]);
      check("tok_unk", tok_unk, exp_unk_q[i]);
      held = tok_id;
      bp = $urandom_range(0, 5);
      tok_ready = 1'b0;
      repeat (bp) begin
        if (poke) begin
          m_done = 1'b1; m_found = 1'b1; m_end = $urandom_range(0, 1);
          m_len = 4'd7; m_token = 8'hEE;
        end
        tick;
        m_done = 1'b0; m_found = 1'b0; m_end = 1'b0; m_len = '0; m_token = '0;
        check("bp_valid_held", tok_valid, 1);
        check("bp_id_stable", tok_id, held);
        check("bp_no_mstart", m_start, 0);
      end
      tok_ready = 1'b1; tick; tok_ready = 1'b0;
      check("valid_drops", tok_valid, 0);
      if (i == exp_base_q.size() - 1) begin
        finish_check();
        return;
      end
      check("mstart_after_accept", m_start, 1);
    end
  endtask

  task automatic gen_random;
    int k, sel;
    resp_q.delete();
    k = $urandom_range(0, 6);
    for (int j = 0; j < k; j++) begin
      sel = $urandom_range(0, 9);
      if (sel < 2)       push(1'b0, 1'b0, $urandom_range(0, 15), $urandom_range(0, 255));
      else if (sel == 2) push(1'b0, 1'b1, 0, $urandom_range(0, 255));
      else               push(1'b0, 1'b1, $urandom_range(1, 15), $urandom_range(0, 255));
    end
    push(1'b1, $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; m_done = 1'b0; m_found = 1'b0; m_end = 1'b0;
    m_len = '0; m_token = '0; tok_ready = 1'b0;
    tick; tick;
    check("rst_m_start", m_start, 0);
    check("rst_m_base", m_base, 0);
    check("rst_tok_valid", tok_valid, 0);
    check("rst_tok_id", tok_id, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tok_count", tok_count, 0);
    check("rst_error", error, 0);
    rst = 1'b0;
    tick;

    // single token, then UNK path, exhaustion, zero-token with end priority, illegal length
    resp_q.delete(); push(0, 1, 3, 'h2A); push(1, 0, 0, 0); run_pass(1'b0);
    resp_q.delete(); push(0, 0, 0, 0); push(0, 1, 2, 'h05); push(1, 0, 0, 0); run_pass(1'b0);
    resp_q.delete(); push(0, 1, 14, 'h09); push(0, 1, 3, 'h11); push(1, 0, 0, 0); run_pass(1'b1);
    resp_q.delete(); push(1, 1, 5, 'h03); run_pass(1'b0);
    resp_q.delete(); push(0, 1, 0, 'h33); push(1, 0, 0, 0); run_pass(1'b1);
    resp_q.delete(); push(0, 1, 15, 'h44); push(1, 0, 0, 0); run_pass(1'b0);

    for (int p = 0; p < 40; p++) begin
      gen_random();
      run_pass(p[0]);
    end

    // reset while a token is pending
    start = 1'b1; tick; start = 1'b0;
    tick;
    m_done = 1'b1; m_found = 1'b1; m_len = 4'd0; m_token = 8'h55;
    tick;
    m_done = 1'b0; m_found = 1'b0;
    check("pre_rst_valid", tok_valid, 1);
    check("pre_rst_error", error, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", tok_valid, 0);
    check("mid_rst_unk", tok_unk, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_error", error, 0);
    check("mid_rst_count", tok_count, 0);
    check("mid_rst_m_start", m_start, 0);
    tick;
    rst = 1'b0;
    repeat (3) begin
      tick;
      check("post_rst_no_done", done, 0);
      check("post_rst_idle", busy, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
